// File: rtl/hash_request_scheduler.sv
// Round-robin front end for the hash table controller: grants one request at a time,
// walks it through lookup and a single commit cycle, then returns the result.
module hash_request_scheduler #(
    parameter int NUM_REQUESTERS = 4,
    parameter int KEY_WIDTH      = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int LOOKUP_LATENCY = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clk_en,
    input  logic                              req_valid_i [NUM_REQUESTERS],
    input  logic [1:0]                        req_op_i    [NUM_REQUESTERS],
    input  logic [KEY_WIDTH-1:0]              req_key_i   [NUM_REQUESTERS],
    input  logic [DATA_WIDTH-1:0]             req_data_i  [NUM_REQUESTERS],
    output logic                              req_ready_o [NUM_REQUESTERS],
    output logic [KEY_WIDTH-1:0]              hash_key_o,
    output logic [DATA_WIDTH-1:0]             hash_data_o,
    output logic [1:0]                        hash_op_o,
    input  logic [DATA_WIDTH-1:0]             hash_read_data_i,
    input  logic                              no_element_found_i,
    input  logic                              no_write_space_i,
    input  logic                              key_already_present_i,
    input  logic                              no_deletion_target_i,
    output logic                              resp_valid_o,
    input  logic                              resp_ready_i,
    output logic [$clog2(NUM_REQUESTERS)-1:0] resp_id_o,
    output logic [DATA_WIDTH-1:0]             resp_data_o,
    output logic [3:0]                        resp_status_o
);

    localparam int ID_W  = $clog2(NUM_REQUESTERS);
    localparam int CNT_W = $clog2(LOOKUP_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_COMMIT,
        S_RESPOND
    } state_t;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [KEY_WIDTH-1:0]  key_q, key_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            op_q, op_d;
    logic [ID_W-1:0]       rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [3:0]            status_q, status_d;

    logic                  grant_vld;
    logic [ID_W-1:0]       grant_idx;

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                                 input int unsigned     off);
        return ID_W'((32'(base) + off) % NUM_REQUESTERS);
    endfunction

    function automatic logic eligible(input logic [ID_W-1:0] idx);
        return req_valid_i[idx] && (req_op_i[idx] != 2'b00);
    endfunction

    // Scan starts one past the last granted index so the previous winner goes last.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 1; k <= NUM_REQUESTERS; k++) begin
            if (!grant_vld && eligible(wrap_idx(ptr_q, k))) begin
                grant_vld = 1'b1;
                grant_idx = wrap_idx(ptr_q, k);
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
            req_ready_o[i] = reset && clk_en && (state_q == S_IDLE) && grant_vld
                             && (grant_idx == ID_W'(i));
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        cnt_d    = cnt_q;
        key_d    = key_q;
        data_d   = data_q;
        op_d     = op_q;
        rid_d    = rid_q;
        rdata_d  = rdata_q;
        status_d = status_q;
        if (clk_en) begin
            unique case (state_q)
                S_IDLE: begin
                    if (grant_vld) begin
                        key_d   = req_key_i[grant_idx];
                        data_d  = req_data_i[grant_idx];
                        op_d    = req_op_i[grant_idx];
                        id_d    = grant_idx;
                        ptr_d   = grant_idx;
                        cnt_d   = CNT_W'(LOOKUP_LATENCY);
                        state_d = S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_COMMIT;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_COMMIT: begin
                    status_d = {no_deletion_target_i, key_already_present_i,
                                no_write_space_i, no_element_found_i};
                    rdata_d  = (op_q == 2'b01) ? hash_read_data_i : '0;
                    rid_d    = id_q;
                    state_d  = S_RESPOND;
                end
                S_RESPOND: begin
                    if (resp_ready_i) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= ID_W'(NUM_REQUESTERS - 1);
            id_q     <= '0;
            cnt_q    <= '0;
            key_q    <= '0;
            data_q   <= '0;
            op_q     <= '0;
            rid_q    <= '0;
            rdata_q  <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            cnt_q    <= cnt_d;
            key_q    <= key_d;
            data_q   <= data_d;
            op_q     <= op_d;
            rid_q    <= rid_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
        end
    end

    assign hash_key_o    = key_q;
    assign hash_data_o   = data_q;
    assign hash_op_o     = (state_q == S_COMMIT) ? op_q : 2'b00;
    assign resp_valid_o  = (state_q == S_RESPOND);
    assign resp_id_o     = rid_q;
    assign resp_data_o   = rdata_q;
    assign resp_status_o = status_q;

endmodule

// File: tb/tb_hash_request_scheduler.sv
// Bench for hash_request_scheduler: a small hash-table controller model drives the
// flag inputs; a key/value map model predicts grants and responses into a scoreboard.
module tb_hash_request_scheduler;

    localparam int N   = 4;
    localparam int KW  = 2;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int IDW = 2;
    localparam int CAP = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_en;
    logic          req_valid [N];
    logic [1:0]    req_op    [N];
    logic [KW-1:0] req_key   [N];
    logic [DW-1:0] req_data  [N];
    logic          req_ready [N];
    logic [KW-1:0] hash_key;
    logic [DW-1:0] hash_data;
    logic [1:0]    hash_op;
    logic [DW-1:0] rd_data;
    logic          f_nef, f_nws, f_kap, f_ndt;
    logic          resp_valid, resp_ready;
    logic [IDW-1:0] resp_id;
    logic [DW-1:0] resp_data;
    logic [3:0]    resp_status;

    hash_request_scheduler #(
        .NUM_REQUESTERS(N),
        .KEY_WIDTH(KW),
        .DATA_WIDTH(DW),
        .LOOKUP_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .req_valid_i(req_valid), .req_op_i(req_op), .req_key_i(req_key),
        .req_data_i(req_data), .req_ready_o(req_ready),
        .hash_key_o(hash_key), .hash_data_o(hash_data), .hash_op_o(hash_op),
        .hash_read_data_i(rd_data),
        .no_element_found_i(f_nef), .no_write_space_i(f_nws),
        .key_already_present_i(f_kap), .no_deletion_target_i(f_ndt),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_id_o(resp_id), .resp_data_o(resp_data), .resp_status_o(resp_status)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- controller environment (table of 4 keys, capacity CAP)
    logic          e_present [1<<KW];
    logic [DW-1:0] e_data    [1<<KW];
    logic [DW-1:0] junk;
    logic [3:0]    junkf;
    int            e_cnt;

    initial begin
        for (int k = 0; k < (1<<KW); k++) begin
            e_present[k] = 1'b0;
            e_data[k]    = '0;
        end
        junk  = '0;
        junkf = '0;
    end

    always_comb begin
        e_cnt = 0;
        for (int k = 0; k < (1<<KW); k++) if (e_present[k]) e_cnt++;
    end

    // Outside commit the flags and read data are garbage; only the commit cycle is meaningful.
    always_comb begin
        rd_data = junk;
        {f_ndt, f_kap, f_nws, f_nef} = junkf;
        if (hash_op != 2'b00) begin
            rd_data = e_data[hash_key];
            {f_ndt, f_kap, f_nws, f_nef} = 4'b0000;
            case (hash_op)
                2'b01: f_nef = !e_present[hash_key];
                2'b10: begin
                    if (e_present[hash_key]) f_kap = 1'b1;
                    else if (e_cnt >= CAP)   f_nws = 1'b1;
                end
                default: f_ndt = !e_present[hash_key];
            endcase
        end
    end

    always @(posedge clk) begin
        junk  <= $urandom;
        junkf <= 4'($urandom_range(0, 15));
        if (reset && clk_en && hash_op != 2'b00) begin
            if (hash_op == 2'b10 && !e_present[hash_key] && e_cnt < CAP) begin
                e_present[hash_key] <= 1'b1;
                e_data[hash_key]    <= hash_data;
            end
            if (hash_op == 2'b11 && e_present[hash_key]) e_present[hash_key] <= 1'b0;
        end
    end

    // ---------------- reference model + scoreboard
    typedef struct {
        int            id;
        logic [1:0]    op;
        logic [KW-1:0] key;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic [3:0]    status;
        int            acc_en;
    } exp_t;

    exp_t          sb[$];
    logic          m_present [1<<KW];
    logic [DW-1:0] m_data    [1<<KW];
    int            m_ptr = N - 1;
    bit            busy = 1'b0;
    int            grant_log[$];
    int            grant_cyc[$];
    int            cyc = 0;
    int            en_cnt = 0;
    int            op_cycles = 0;
    bit            prev_valid = 1'b0;
    bit            prev_taken = 1'b0;
    logic [IDW-1:0] prev_id;
    logic [DW-1:0] prev_data;
    logic [3:0]    prev_status;

    initial begin
        for (int k = 0; k < (1<<KW); k++) begin
            m_present[k] = 1'b0;
            m_data[k]    = '0;
        end
    end

    function automatic int pick();
        for (int k = 1; k <= N; k++) begin
            int i = (m_ptr + k) % N;
            if (req_valid[i] && req_op[i] != 2'b00) return i;
        end
        return -1;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int k = 0; k < (1<<KW); k++) if (m_present[k]) c++;
        return c;
    endfunction

    function automatic void model_apply(inout exp_t e);
        e.rdata  = '0;
        e.status = 4'b0000;
        case (e.op)
            2'b01: begin
                e.rdata = m_data[e.key];
                if (!m_present[e.key]) e.status = 4'b0001;
            end
            2'b10: begin
                if (m_present[e.key])     e.status = 4'b0100;
                else if (m_count() >= CAP) e.status = 4'b0010;
                else begin
                    m_present[e.key] = 1'b1;
                    m_data[e.key]    = e.wdata;
                end
            end
            default: begin
                if (!m_present[e.key]) e.status = 4'b1000;
                else m_present[e.key] = 1'b0;
            end
        endcase
    endfunction

    always @(negedge clk) begin
        int   exp_g, act_g, nact;
        exp_t e;
        if (!reset) begin
            sb.delete();
            busy       = 1'b0;
            m_ptr      = N - 1;
            prev_valid = 1'b0;
        end else begin
            exp_g = (!busy && clk_en) ? pick() : -1;
            act_g = -1;
            nact  = 0;
            for (int i = 0; i < N; i++) if (req_ready[i]) begin act_g = i; nact++; end
            check("ready_onehot", 64'(nact > 1), 64'd0);
            check("grant", 64'(act_g), 64'(exp_g));
            if (act_g >= 0) begin
                e.id     = act_g;
                e.op     = req_op[act_g];
                e.key    = req_key[act_g];
                e.wdata  = req_data[act_g];
                e.acc_en = en_cnt;
                model_apply(e);
                sb.push_back(e);
                busy      = 1'b1;
                m_ptr     = act_g;
                op_cycles = 0;
                grant_log.push_back(act_g);
                grant_cyc.push_back(cyc);
            end
            if (hash_op != 2'b00) begin
                if (sb.size() == 0) check("spurious_commit", 64'(hash_op), 64'd0);
                else begin
                    check("commit_op", 64'(hash_op), 64'(sb[0].op));
                    check("commit_key", 64'(hash_key), 64'(sb[0].key));
                    check("commit_data", 64'(hash_data), 64'(sb[0].wdata));
                end
                if (clk_en) op_cycles++;
            end
            if (resp_valid) begin
                if (sb.size() == 0) check("unexpected_resp", 64'(resp_valid), 64'd0);
                else begin
                    if (!prev_valid) check("resp_latency", 64'(en_cnt - sb[0].acc_en), 64'(LAT + 2));
                    if (prev_valid && !prev_taken) begin
                        check("resp_stable_id", 64'(resp_id), 64'(prev_id));
                        check("resp_stable_data", 64'(resp_data), 64'(prev_data));
                        check("resp_stable_status", 64'(resp_status), 64'(prev_status));
                    end
                    if (resp_ready && clk_en) begin
                        e = sb.pop_front();
                        check("resp_id", 64'(resp_id), 64'(e.id));
                        check("resp_data", 64'(resp_data), 64'(e.rdata));
                        check("resp_status", 64'(resp_status), 64'(e.status));
                        check("commit_cycles", 64'(op_cycles), 64'd1);
                        busy = 1'b0;
                    end
                end
            end else if (prev_valid && !prev_taken) begin
                check("resp_dropped", 64'(resp_valid), 64'd1);
            end
            prev_valid  = resp_valid;
            prev_taken  = resp_ready && clk_en;
            prev_id     = resp_id;
            prev_data   = resp_data;
            prev_status = resp_status;
            if (clk_en) en_cnt++;
            cyc++;
        end
    end

    // ---------------- stimulus
    function automatic logic any_ready();
        for (int i = 0; i < N; i++) if (req_ready[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        if (busy) check("idle_timeout", 64'(busy), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic issue(input int r, input logic [1:0] op, input logic [KW-1:0] key,
                         input logic [DW-1:0] data);
        int n = 0;
        req_valid[r] = 1'b1;
        req_op[r]    = op;
        req_key[r]   = key;
        req_data[r]  = data;
        do begin @(negedge clk); n++; end while (!req_ready[r] && n < 100);
        if (!req_ready[r]) check("issue_timeout", 64'(r), 64'hFF);
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_resp_valid();
        int n = 0;
        while (!resp_valid && n < 50) begin @(negedge clk); n++; end
        if (!resp_valid) check("resp_timeout", 64'(resp_valid), 64'd1);
    endtask

    initial begin
        int start, n;
        reset = 1'b0; clk_en = 1'b1; resp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b0; req_op[i] = 2'b00; req_key[i] = '0; req_data[i] = '0;
        end
        #3;
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_hash_op", 64'(hash_op), 64'd0);
        check("rst_hash_key", 64'(hash_key), 64'd0);
        check("rst_hash_data", 64'(hash_data), 64'd0);
        check("rst_resp_id", 64'(resp_id), 64'd0);
        check("rst_resp_data", 64'(resp_data), 64'd0);
        check("rst_resp_status", 64'(resp_status), 64'd0);
        check("rst_ready", 64'(any_ready()), 64'd0);
        @(posedge clk); #2 reset = 1'b1;

        // round robin: everyone writes key 1; first succeeds, the rest collide
        start = grant_log.size();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b1; req_op[i] = 2'b10; req_key[i] = 2'd1; req_data[i] = $urandom;
        end
        n = 0;
        while (grant_log.size() < start + 5 && n < 200) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) req_valid[i] = 1'b0;
        if (grant_log.size() < start + 5) check("rr_timeout", 64'(grant_log.size()), 64'(start + 5));
        else begin
            for (int k = 0; k < 5; k++) check("rr_order", 64'(grant_log[start+k]), 64'(k % N));
            for (int k = 1; k < 5; k++)
                check("rr_spacing", 64'(grant_cyc[start+k] - grant_cyc[start+k-1]), 64'(LAT + 3));
        end
        wait_idle();

        issue(0, 2'b10, 2'd2, 32'hDEADBEEF);
        wait_idle();

        // single read, exact cycle positions
        req_valid[1] = 1'b1; req_op[1] = 2'b01; req_key[1] = 2'd2; req_data[1] = '0;
        @(negedge clk);
        check("rd_ready_t0", 64'(req_ready[1]), 64'd1);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            @(negedge clk);
            check("rd_hash_op", 64'(hash_op), (t == 3) ? 64'd1 : 64'd0);
            check("rd_resp_valid", 64'(resp_valid), (t == 4) ? 64'd1 : 64'd0);
        end
        wait_idle();

        // response backpressure with competing requests pending
        resp_ready = 1'b0;
        issue(2, 2'b01, 2'd2, '0);
        req_valid[0] = 1'b1; req_op[0] = 2'b10; req_key[0] = 2'd3; req_data[0] = $urandom;
        req_valid[3] = 1'b1; req_op[3] = 2'b10; req_key[3] = 2'd3; req_data[3] = $urandom;
        wait_resp_valid();
        repeat (6) begin
            @(negedge clk);
            check("bp_valid", 64'(resp_valid), 64'd1);
            check("bp_no_ready", 64'(any_ready()), 64'd0);
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_grant", 64'(any_ready()), 64'd1);
        check("bp_valid_low", 64'(resp_valid), 64'd0);
        @(posedge clk); #1 req_valid[0] = 1'b0; req_valid[3] = 1'b0;
        wait_idle();

        // clock-enable gap of 3 cycles inside LOOKUP
        issue(3, 2'b01, 2'd1, '0);
        for (int k = 1; k <= 6; k++) begin
            clk_en = (k >= 2 && k <= 4) ? 1'b0 : 1'b1;
            @(negedge clk);
            check("gate_hash_op", 64'(hash_op), (k == 6) ? 64'd1 : 64'd0);
            check("gate_ready", 64'(any_ready()), 64'd0);
            @(posedge clk); #1;
        end
        clk_en = 1'b1;
        wait_idle();

        // randomized traffic
        repeat (400) begin
            @(posedge clk); #1;
            clk_en     = ($urandom_range(0, 9) != 0);
            resp_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    req_op[i]    = 2'($urandom_range(0, 3));
                    req_key[i]   = KW'($urandom_range(0, 3));
                    req_data[i]  = $urandom;
                end
            end
        end
        clk_en = 1'b1; resp_ready = 1'b1;
        for (int i = 0; i < N; i++) req_valid[i] = 1'b0;
        wait_idle();

        // asynchronous reset while a response is waiting
        resp_ready = 1'b0;
        issue(1, 2'b01, 2'd2, '0);
        req_valid[0] = 1'b1; req_op[0] = 2'b01; req_key[0] = 2'd0;
        req_valid[3] = 1'b1; req_op[3] = 2'b00; req_key[3] = 2'd1;
        wait_resp_valid();
        @(negedge clk); #2 reset = 1'b0;
        #1;
        check("arst_resp_valid", 64'(resp_valid), 64'd0);
        check("arst_hash_op", 64'(hash_op), 64'd0);
        check("arst_ready", 64'(any_ready()), 64'd0);
        check("arst_resp_id", 64'(resp_id), 64'd0);
        check("arst_resp_data", 64'(resp_data), 64'd0);
        check("arst_resp_status", 64'(resp_status), 64'd0);
        check("arst_hash_key", 64'(hash_key), 64'd0);
        repeat (2) begin
            @(negedge clk);
            check("arst_hold_ready", 64'(any_ready()), 64'd0);
        end
        @(posedge clk); #2 reset = 1'b1; resp_ready = 1'b1;
        @(negedge clk);
        check("arst_first_grant0", 64'(req_ready[0]), 64'd1);
        check("arst_no_grant3", 64'(req_ready[3]), 64'd0);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        repeat (12) begin
            @(negedge clk);
            check("op00_never_granted", 64'(req_ready[3]), 64'd0);
        end
        req_valid[3] = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
